// File: rtl/video_pattern_gen_pkg.sv
// Shared types and constants for the video pattern generator.
//   state_t   : frame sequencer states
//   pattern_t : selectable test patterns
package video_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LINE   = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIAG  = 2'd0,
        XRAMP = 2'd1,
        YRAMP = 2'd2,
        CONST = 2'd3
    } pattern_t;

    // Shortest blanking interval; a programmed length of 0 is raised to this.
    localparam int unsigned MIN_BLANK       = 1;
    localparam int unsigned GAP_WIDTH       = 4;
    localparam int unsigned FRAME_CNT_WIDTH = 16;

endpackage

// File: rtl/video_pattern_gen_if.sv
// Video stream bundle as consumed by the scaler and monitor.
//   do_o : pixel data, valid while de_o=1
//   de_o : pixel strobe
//   hs_o : 1 outside the active line
//   vs_o : 1 during the frame, 0 in vertical blanking / idle
interface video_pattern_gen_if #(
    parameter int unsigned PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0] do_o;
    logic                   de_o;
    logic                   hs_o;
    logic                   vs_o;

    modport master (output do_o, de_o, hs_o, vs_o);
    modport slave  (input  do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/video_pattern_gen_pix.sv
// Combinational pixel value for coordinate (x, y) under the selected pattern.
//   x, y      : pixel coordinates
//   frame_ofs : per-frame offset added to patterns DIAG/XRAMP/YRAMP
//   pattern   : pattern select
//   const_val : value for CONST
//   pix_c     : pixel value, modulo 2^PIXEL_WIDTH
module video_pattern_pix
    import video_gen_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic [CNT_WIDTH-1:0]   x,
    input  logic [CNT_WIDTH-1:0]   y,
    input  logic [PIXEL_WIDTH-1:0] frame_ofs,
    input  pattern_t               pattern,
    input  logic [PIXEL_WIDTH-1:0] const_val,
    output logic [PIXEL_WIDTH-1:0] pix_c
);

    always_comb begin
        pix_c = const_val;
        case (pattern)
            DIAG:    pix_c = PIXEL_WIDTH'(x) + PIXEL_WIDTH'(y) + frame_ofs;
            XRAMP:   pix_c = PIXEL_WIDTH'(x) + frame_ofs;
            YRAMP:   pix_c = PIXEL_WIDTH'(y) + frame_ofs;
            CONST:   pix_c = const_val;
            default: pix_c = const_val;
        endcase
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source with programmable size, blanking and sparse DE.
// Optional feature macro: VIDEO_PATTERN_GEN_FRAME_CNT_EN (frame counter
// output and scrolling patterns).
//   clk, rst_n    : clock, asynchronous active-low reset
//   en_i          : run request, sampled in IDLE and at the end of VBLANK
//   reg_*         : frame configuration, captured at each frame start
//   vid           : video stream (do_o/de_o/hs_o/vs_o)
//   busy_o        : 1 while not in IDLE
//   frame_cnt_o   : completed-frame counter (macro builds only)
module video_pattern_gen
    import video_gen_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [CNT_WIDTH-1:0]   reg_width,
    input  logic [CNT_WIDTH-1:0]   reg_height,
    input  logic [CNT_WIDTH-1:0]   reg_hblank,
    input  logic [CNT_WIDTH-1:0]   reg_vblank,
    input  logic [GAP_WIDTH-1:0]   reg_de_gap,
    input  logic [1:0]             reg_pattern,
    input  logic [PIXEL_WIDTH-1:0] reg_const,
    video_pattern_gen_if.master    vid,
    output logic                   busy_o
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o
`endif
);

    // Index of the final cycle of a blanking interval of max(len,1) cycles.
    function automatic logic [CNT_WIDTH-1:0] last_cycle(input logic [CNT_WIDTH-1:0] len);
        return (len < CNT_WIDTH'(MIN_BLANK)) ? '0 : len - CNT_WIDTH'(MIN_BLANK);
    endfunction

    state_t                 state_q, state_n;
    logic [CNT_WIDTH-1:0]   x_q, x_n, y_q, y_n, bc_q, bc_n;
    logic [GAP_WIDTH-1:0]   gc_q, gc_n;

    // Shadow copy of the configuration, stable for a whole frame.
    logic [CNT_WIDTH-1:0]   w_q, w_n, h_q, h_n, hb_q, hb_n, vb_q, vb_n;
    logic [GAP_WIDTH-1:0]   gap_q, gap_n;
    pattern_t               pat_q, pat_n;
    logic [PIXEL_WIDTH-1:0] const_q, const_n;

    logic [PIXEL_WIDTH-1:0] do_q, do_n, pix_c, frame_ofs_c;
    logic                   de_q, de_n, hs_q, hs_n, vs_q, vs_n, busy_q, busy_n;
    logic                   start_ok_c, load_c;

`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
    logic [FRAME_CNT_WIDTH-1:0] fc_q, fc_n;
    assign frame_ofs_c = PIXEL_WIDTH'(fc_n);
    assign frame_cnt_o = fc_q;
`else
    assign frame_ofs_c = '0;
`endif

    // A frame may only start with a non-empty geometry.
    assign start_ok_c = en_i && (reg_width != '0) && (reg_height != '0);

    // Frame sequencer: next state, counters and shadow reload.
    always_comb begin : next_state
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        gc_n    = gc_q;
        bc_n    = bc_q;
        load_c  = 1'b0;
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
        fc_n    = fc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_ok_c) begin
                    load_c  = 1'b1;
                    state_n = LINE;
                end
            end
            LINE: begin
                if (gc_q == gap_q) begin
                    if (x_q == w_q - CNT_WIDTH'(1)) begin
                        bc_n = '0;
                        if (y_q == h_q - CNT_WIDTH'(1)) begin
                            state_n = VBLANK;
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
                            fc_n    = fc_q + FRAME_CNT_WIDTH'(1);
`endif
                        end else begin
                            state_n = HBLANK;
                        end
                    end else begin
                        x_n  = x_q + CNT_WIDTH'(1);
                        gc_n = '0;
                    end
                end else begin
                    gc_n = gc_q + GAP_WIDTH'(1);
                end
            end
            HBLANK: begin
                if (bc_q == last_cycle(hb_q)) begin
                    state_n = LINE;
                    x_n     = '0;
                    y_n     = y_q + CNT_WIDTH'(1);
                    gc_n    = '0;
                end else begin
                    bc_n = bc_q + CNT_WIDTH'(1);
                end
            end
            VBLANK: begin
                if (bc_q == last_cycle(vb_q)) begin
                    if (start_ok_c) begin
                        load_c  = 1'b1;
                        state_n = LINE;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    bc_n = bc_q + CNT_WIDTH'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Frame start: capture configuration and restart at (0,0).
        w_n     = w_q;
        h_n     = h_q;
        hb_n    = hb_q;
        vb_n    = vb_q;
        gap_n   = gap_q;
        pat_n   = pat_q;
        const_n = const_q;
        if (load_c) begin
            x_n     = '0;
            y_n     = '0;
            gc_n    = '0;
            w_n     = reg_width;
            h_n     = reg_height;
            hb_n    = reg_hblank;
            vb_n    = reg_vblank;
            gap_n   = reg_de_gap;
            pat_n   = pattern_t'(reg_pattern);
            const_n = reg_const;
        end
    end

    video_pattern_pix #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_pix (
        .x         (x_n),
        .y         (y_n),
        .frame_ofs (frame_ofs_c),
        .pattern   (pat_n),
        .const_val (const_n),
        .pix_c     (pix_c)
    );

    // Outputs are derived from the next state so the registered copies line
    // up with the state they describe.
    always_comb begin : next_outputs
        de_n   = (state_n == LINE) && (gc_n == gap_n);
        do_n   = de_n ? pix_c : do_q;
        hs_n   = (state_n != LINE);
        vs_n   = (state_n == LINE) || (state_n == HBLANK);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            gc_q    <= '0;
            bc_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            hb_q    <= '0;
            vb_q    <= '0;
            gap_q   <= '0;
            pat_q   <= DIAG;
            const_q <= '0;
            do_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
            fc_q    <= '0;
`endif
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            gc_q    <= gc_n;
            bc_q    <= bc_n;
            w_q     <= w_n;
            h_q     <= h_n;
            hb_q    <= hb_n;
            vb_q    <= vb_n;
            gap_q   <= gap_n;
            pat_q   <= pat_n;
            const_q <= const_n;
            do_q    <= do_n;
            de_q    <= de_n;
            hs_q    <= hs_n;
            vs_q    <= vs_n;
            busy_q  <= busy_n;
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
            fc_q    <= fc_n;
`endif
        end
    end

    assign vid.do_o = do_q;
    assign vid.de_o = de_q;
    assign vid.hs_o = hs_q;
    assign vid.vs_o = vs_q;
    assign busy_o   = busy_q;

endmodule
